// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch port and the data port.
// Only one access is in flight at a time. The data port wins ties, then the two ports alternate.
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_DONE,
  output logic [DW-1:0] IF_RDATA,
  output logic          IF_STALL,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_DONE,
  output logic [DW-1:0] D_RDATA,
  output logic          D_STALL,
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  // state   | meaning
  // S_IDLE  | no access in flight, grant rule active
  // S_ISSUE | MEM_CSN low for the granted access
  // S_WAIT  | read latency countdown, capture at cnt==0
  // S_RESP  | owner's DONE pulses, grant rule active for the next access
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam int   CW     = (LAT > 1) ? $clog2(LAT) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          last_owner;
  logic          acc_we;
  logic          if_elig;
  logic          d_elig;
  logic          grant_en;
  logic          grant_d;

  // The port pulsing DONE is masked, so the served port cannot be re-granted in RESP.
  always_comb begin
    if_elig  = IF_REQ & ~IF_DONE;
    d_elig   = D_REQ & ~D_DONE;
    grant_en = ((state == S_IDLE) || (state == S_RESP)) && (if_elig || d_elig);
    if (if_elig && d_elig) grant_d = (last_owner == OWN_IF);
    else                   grant_d = d_elig;
  end

  assign IF_STALL = IF_REQ & ~IF_DONE;
  assign D_STALL  = D_REQ & ~D_DONE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      acc_we     <= 1'b0;
      IF_DONE    <= 1'b0;
      D_DONE     <= 1'b0;
      IF_RDATA   <= '0;
      D_RDATA    <= '0;
      MEM_CSN    <= 1'b1;
      MEM_WEN    <= 1'b1;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
    end else begin
      IF_DONE <= 1'b0;
      D_DONE  <= 1'b0;
      MEM_CSN <= 1'b1;
      MEM_WEN <= 1'b1;
      case (state)
        S_IDLE, S_RESP: begin
          if (state == S_RESP) last_owner <= owner;
          if (grant_en) begin
            owner     <= grant_d;
            acc_we    <= grant_d & D_WE;
            MEM_ADDR  <= grant_d ? D_ADDR : IF_ADDR;
            MEM_WDATA <= D_WDATA;
            MEM_CSN   <= 1'b0;
            MEM_WEN   <= ~(grant_d & D_WE);
            state     <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (acc_we) begin
            if (owner == OWN_D) D_DONE  <= 1'b1;
            else                IF_DONE <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt   <= CW'(LAT - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (owner == OWN_D) begin
              D_RDATA <= MEM_RDATA;
              D_DONE  <= 1'b1;
            end else begin
              IF_RDATA <= MEM_RDATA;
              IF_DONE  <= 1'b1;
            end
            state <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-port traffic against a transaction-timing model: each grant books
// CSN, capture and DONE cycles from the access type, and the memory answers after LAT cycles.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NCYC = 4000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IF_REQ, IF_DONE, IF_STALL;
  logic [AW-1:0] IF_ADDR;
  logic [DW-1:0] IF_RDATA;
  logic          D_REQ, D_WE, D_DONE, D_STALL;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA, D_RDATA;
  logic          MEM_CSN, MEM_WEN;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DONE(IF_DONE), .IF_RDATA(IF_RDATA), .IF_STALL(IF_STALL),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_DONE(D_DONE), .D_RDATA(D_RDATA), .D_STALL(D_STALL),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: one booked transaction plus the latched/held outputs
  bit            busy, own_d, own_we, last_d;
  int            issue_c, rd_c, done_c;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_if_rdata, exp_d_rdata, rd_val;
  bit            prev_if_done, prev_d_done;
  int            mem_c = -1;
  logic [DW-1:0] mem_v;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit do_check);
    bit e_csn, e_ifd, e_dd, ei, ed;
    e_csn = !(busy && issue_c == cyc);
    e_ifd = busy && done_c == cyc && !own_d;
    e_dd  = busy && done_c == cyc && own_d;
    if (do_check) begin
      check_eq("csn", MEM_CSN, e_csn);
      if (!e_csn) begin
        check_eq("wen", MEM_WEN, !(own_d && own_we));
        if (own_we) check_eq("wdata", MEM_WDATA, exp_wdata);
      end
      check_eq("addr", MEM_ADDR, exp_addr);
      check_eq("if_done", IF_DONE, e_ifd);
      check_eq("d_done", D_DONE, e_dd);
      check_eq("if_rdata", IF_RDATA, exp_if_rdata);
      check_eq("d_rdata", D_RDATA, exp_d_rdata);
      check_eq("if_stall", IF_STALL, IF_REQ && !e_ifd);
      check_eq("d_stall", D_STALL, D_REQ && !e_dd);
    end
    prev_if_done = e_ifd;
    prev_d_done  = e_dd;
    if (RST) begin
      busy = 0; last_d = 0;
      exp_addr = '0; exp_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0;
    end else begin
      if (busy && !own_we && rd_c == cyc) begin
        if (own_d) exp_d_rdata = rd_val;
        else       exp_if_rdata = rd_val;
      end
      if (busy && done_c == cyc) begin
        last_d = own_d;
        busy   = 0;
      end
      if (!busy) begin
        ei = IF_REQ && !e_ifd;
        ed = D_REQ && !e_dd;
        if (ei || ed) begin
          own_d    = (ei && ed) ? !last_d : ed;
          own_we   = own_d && D_WE;
          exp_addr = own_d ? D_ADDR : IF_ADDR;
          if (own_we) exp_wdata = D_WDATA;
          busy    = 1;
          issue_c = cyc + 1;
          rd_c    = cyc + 1 + LAT;
          done_c  = own_we ? cyc + 2 : cyc + 2 + LAT;
          if (!own_we) begin
            rd_val = $urandom;
            mem_c  = rd_c;
            mem_v  = rd_val;
          end
        end
      end
    end
  endtask

  task automatic drive();
    if (cyc < 2) begin
      RST = 1'b1;
    end else begin
      RST = ($urandom_range(0, 199) == 0);
      if (IF_REQ && prev_if_done) IF_REQ = 1'b0;
      if (!IF_REQ && ($urandom_range(0, 2) == 0)) begin
        IF_REQ  = 1'b1;
        IF_ADDR = $urandom;
      end
      if (D_REQ && prev_d_done) D_REQ = 1'b0;
      if (!D_REQ && ($urandom_range(0, 2) == 0)) begin
        D_REQ   = 1'b1;
        D_WE    = $urandom_range(0, 1);
        D_ADDR  = $urandom;
        D_WDATA = $urandom;
      end
    end
    MEM_RDATA = (cyc == mem_c) ? mem_v : DW'($urandom);
  endtask

  initial begin
    RST = 1'b1;
    IF_REQ = 1'b1; IF_ADDR = 32'h100;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h40; D_WDATA = 32'h55;
    MEM_RDATA = '0;
    busy = 0; last_d = 0; own_d = 0; own_we = 0;
    issue_c = -1; rd_c = -1; done_c = -1;
    exp_addr = '0; exp_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0; rd_val = '0; mem_v = '0;
    prev_if_done = 0; prev_d_done = 0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge CLK);
      step(cyc >= 1);
      @(posedge CLK);
      #1;
      cyc++;
      drive();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
